multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Multi-cycle sequencer for the 8-bit, 4-register processor.
- Owns the PC and instruction register, and fetches from the combinational instruction memory.
- Decodes the 2-bit opcode field and drives register-file, ALU and data-memory control.
- Runs a req/ack handshake with data memory, with a watchdog, halt detection and a retired-instruction counter.

Parameters:
- PC_W, 8, width of PC and instruction-memory address
- IW, 8, instruction width; fields op=[7:6], rs=[5:4], rt=[3:2], rd=[1:0]; jump offset=[5:0]
- ACK_TIMEOUT, 15, maximum cycles spent in MEM waiting for dmem_ack
- CNT_W, 16, width of the retired-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins execution from PC 0
- imem_addr  out  PC_W  instruction-memory address, equals pc
- imem_data  in  IW  instruction-memory data, combinational from imem_addr
- pc  out  PC_W  current program counter
- ir  out  IW  latched instruction
- reg_write  out  1  register-file write enable, WB state only
- reg_dst  out  1  1 = write rd (add), 0 = write rt (lw)
- alu_src  out  1  1 = sign-extended ir[1:0] as ALU operand B (lw/sw)
- mem_to_reg  out  1  1 = writeback data comes from data memory
- dmem_req  out  1  data-memory request
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req is high
- dmem_ack  in  1  data-memory completion
- busy  out  1  high in every state except IDLE and HALT
- halted  out  1  high in HALT
- error  out  1  set on watchdog expiry, sticky until start or reset
- retired  out  CNT_W  count of completed instructions, saturating

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, and dominates all other inputs, including mid-handshake.
- Reset values: state=IDLE, pc=0, ir=0, retired=0, error=0. All control outputs and dmem_req/dmem_we are 0. busy=0, halted=0.
- Opcodes: 00 add, 01 lw, 10 sw, 11 jump.
- Control outputs are Moore-decoded from state and ir only.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE: on start, pc<=0, retired<=0, error<=0, go to FETCH.
- FETCH: ir<=imem_data and pc<=pc+1 (mod 2^PC_W, so 0xFF wraps to 0x00). Go to DECODE.
- DECODE: one cycle, then EXEC.
- EXEC:
  - add -> WB.
  - lw or sw -> MEM; load the watchdog with 0.
  - jump -> pc<=pc+sext(ir[5:0]), mod 2^PC_W. pc already holds the address of the next instruction.
  - If ir[5:0]==6'b111111 (jump-to-self), go to HALT and count the jump as retired. Otherwise retire and go to FETCH.
- MEM:
  - dmem_req=1; dmem_we=1 for sw.
  - If dmem_ack is high in the same cycle: lw -> WB; sw -> retire and go to FETCH. An ack in the first MEM cycle is valid.
  - Otherwise the watchdog increments. When it reaches ACK_TIMEOUT without ack: error<=1, go to HALT, nothing is retired.
  - dmem_ack seen outside MEM is ignored.
- WB: reg_write=1. reg_dst=1 for add. mem_to_reg=1 and alu_src=1 for lw. Retire, then go to FETCH.
- Latencies with immediate ack:
  - add: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - jump: 3 cycles
- HALT:
  - halted=1, busy=0; pc, ir and retired hold.
  - start -> same action as in IDLE.
  - Otherwise stay in HALT.
- start while busy is ignored.
- retired saturates at 2^CNT_W-1.
- The watchdog counter width is clog2(ACK_TIMEOUT+1).

Decomposition:
- Shared package holds:
  - opcode constants OP_ADD, OP_LW, OP_SW, OP_JMP
  - state encoding
  - field bit-position constants
- One sub-module: ack_watchdog.
  - Ports: clk, reset, clear, enable, expired.
  - Parameter: ACK_TIMEOUT.
- All other logic lives in the top-level FSM.

Test Plan:
- Reset/idle: assert reset for 2 cycles, then hold start low for 10 cycles -> state IDLE, pc=0, busy=0, dmem_req=0, retired=0.
- add timing: mem[0]=0x1B (add rs=1, rt=2, rd=3), pulse start ->
  - ir=0x1B one cycle after FETCH
  - reg_write=1 and reg_dst=1 in cycle 4 only
  - retired=1, pc=1
- lw with delayed ack: mem[0]=0x49, ack 3 cycles after dmem_req rises ->
  - dmem_req high exactly 4 cycles with dmem_we=0
  - WB with mem_to_reg=1 follows immediately
  - retired=1
- sw with same-cycle ack: mem[0]=0x99 (sw), ack tied high ->
  - dmem_req and dmem_we high for 1 cycle
  - reg_write never asserts
  - next FETCH has pc=1
- jump and halt: mem[0]=0xC1, mem[2]=0xFF ->
  - pc sequence 0 -> 2 -> 2
  - halted=1, retired=2, busy=0
  - a later start restarts at pc=0
- Watchdog and mid-operation reset: lw with ack never asserted ->
  - after ACK_TIMEOUT cycles in MEM: error=1, halted=1, retired=0
  - on rerun, asserting reset during MEM -> IDLE next cycle with dmem_req=0

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller_pkg
// Brief    : Shared opcode, state-encoding and instruction-field constants
//            for the multi-cycle sequencer of the 8-bit, 4-register CPU.
// Revision : 1.0 - initial release
// ============================================================================
package multicycle_controller_pkg;

    // Opcode field values
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_LW  = 2'b01;
    localparam logic [1:0] OP_SW  = 2'b10;
    localparam logic [1:0] OP_JMP = 2'b11;

    // Sequencer state encoding
    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] S_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] S_FETCH  = 3'd1;
    localparam logic [STATE_W-1:0] S_DECODE = 3'd2;
    localparam logic [STATE_W-1:0] S_EXEC   = 3'd3;
    localparam logic [STATE_W-1:0] S_MEM    = 3'd4;
    localparam logic [STATE_W-1:0] S_WB     = 3'd5;
    localparam logic [STATE_W-1:0] S_HALT   = 3'd6;

    // Instruction field positions
    localparam int OP_MSB   = 7;
    localparam int OP_LSB   = 6;
    localparam int JOFF_MSB = 5;
    localparam int JOFF_LSB = 0;
    localparam int JOFF_W   = JOFF_MSB - JOFF_LSB + 1;

    // A jump whose offset is -1 targets itself and is treated as halt
    localparam logic [JOFF_W-1:0] JOFF_SELF = '1;

endpackage
`default_nettype wire

// File: rtl/multicycle_controller_ack_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : ack_watchdog
// Brief    : Counts data-memory wait cycles and flags the cycle in which the
//            wait budget of ACK_TIMEOUT cycles is used up without an ack.
// Revision : 1.0 - initial release
// ============================================================================
module ack_watchdog #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] C_LAST = CW'(ACK_TIMEOUT - 1);
    localparam logic [CW-1:0] C_MAX  = '1;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins, otherwise count waiting cycles, saturating
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != C_MAX)) begin
            count_d = count_q + CW'(1);
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The wait that would push the count to ACK_TIMEOUT is the last one allowed
    assign expired = enable && (count_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller
// Brief    : Multi-cycle sequencer: owns PC/IR, fetches from a combinational
//            instruction memory, decodes add/lw/sw/jump, drives datapath
//            control, handshakes with data memory under a watchdog, detects
//            halt and counts retired instructions.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int PC_W        = 8,
    parameter int IW          = 8,
    parameter int ACK_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [IW-1:0]    imem_data,
    output logic [PC_W-1:0]  pc,
    output logic [IW-1:0]    ir,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             alu_src,
    output logic             mem_to_reg,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             busy,
    output logic             halted,
    output logic             error,
    output logic [CNT_W-1:0] retired
);
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    pc_d;
    logic [IW-1:0]      ir_q;
    logic [IW-1:0]      ir_d;
    logic [CNT_W-1:0]   retired_q;
    logic [CNT_W-1:0]   retired_d;
    logic               error_q;
    logic               error_d;

    logic               w_retire;
    logic               w_restart;
    logic [1:0]         w_op;
    logic [PC_W-1:0]    w_jump_off;
    logic               w_jump_self;
    logic               w_wd_clear;
    logic               w_wd_enable;
    logic               w_wd_expired;

    assign w_op        = ir_q[OP_MSB:OP_LSB];
    assign w_jump_off  = {{(PC_W-JOFF_W){ir_q[JOFF_MSB]}}, ir_q[JOFF_MSB:JOFF_LSB]};
    assign w_jump_self = (ir_q[JOFF_MSB:JOFF_LSB] == JOFF_SELF);

    // Watchdog is rearmed in EXEC and only counts MEM cycles that lack an ack
    assign w_wd_clear  = (state_q == S_EXEC);
    assign w_wd_enable = (state_q == S_MEM) && !dmem_ack;

    ack_watchdog #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_ack_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_wd_clear),
        .enable  (w_wd_enable),
        .expired (w_wd_expired)
    );

    // State and architectural registers; reset overrides everything
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            retired_q <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
            error_q   <= error_d;
        end
    end

    // Next-state, PC/IR update, retire and error decisions
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        error_d   = error_q;
        w_retire  = 1'b0;
        w_restart = 1'b0;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    w_restart = 1'b1;
                    pc_d      = '0;
                    error_d   = 1'b0;
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: begin
                ir_d    = imem_data;
                pc_d    = pc_q + PC_W'(1);
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (w_op)
                    OP_ADD:  state_d = S_WB;
                    OP_LW:   state_d = S_MEM;
                    OP_SW:   state_d = S_MEM;
                    default: begin
                        // pc already points past the jump, so the offset is
                        // relative to the next instruction
                        pc_d     = pc_q + w_jump_off;
                        w_retire = 1'b1;
                        state_d  = w_jump_self ? S_HALT : S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                if (dmem_ack) begin
                    if (w_op == OP_LW) begin
                        state_d = S_WB;
                    end else begin
                        w_retire = 1'b1;
                        state_d  = S_FETCH;
                    end
                end else if (w_wd_expired) begin
                    error_d = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_WB: begin
                w_retire = 1'b1;
                state_d  = S_FETCH;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        retired_d = retired_q;
        if (w_restart) begin
            retired_d = '0;
        end else if (w_retire && (retired_q != C_CNT_MAX)) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    // Moore control decode from state and latched instruction
    always_comb begin
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        busy       = (state_q != S_IDLE) && (state_q != S_HALT);
        halted     = (state_q == S_HALT);

        case (state_q)
            S_EXEC: begin
                alu_src = (w_op == OP_LW) || (w_op == OP_SW);
            end
            S_MEM: begin
                alu_src  = 1'b1;
                dmem_req = 1'b1;
                dmem_we  = (w_op == OP_SW);
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (w_op == OP_ADD);
                mem_to_reg = (w_op == OP_LW);
                alu_src    = (w_op == OP_LW);
            end
            default: begin
            end
        endcase
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign retired   = retired_q;
    assign error     = error_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_controller
// Brief    : Self-checking bench for multicycle_controller: directed scenarios
//            plus random programs checked against an instruction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;
    localparam int PC_W  = 8;
    localparam int IW    = 8;
    localparam int T     = 15;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [PC_W-1:0]  imem_addr;
    logic [IW-1:0]    imem_data;
    logic [PC_W-1:0]  pc;
    logic [IW-1:0]    ir;
    logic             reg_write, reg_dst, alu_src, mem_to_reg;
    logic             dmem_req, dmem_we;
    logic             dmem_ack = 1'b0;
    logic             busy, halted, error;
    logic [CNT_W-1:0] retired;

    logic [7:0] imem [256];
    int         delays [64];
    int         ack_mode  = 2;   // 0: per-access delay table, 1: tied high, 2: never
    int         acc_cnt   = 0;   // accesses acknowledged so far (driver owned)
    int         acc_start = 0;   // acc_cnt value at the start of the current run
    int         mem_cyc   = 0;
    int         errors    = 0;
    int         checks    = 0;

    assign imem_data = imem[imem_addr];

    always #5 clk = ~clk;

    multicycle_controller #(
        .PC_W(PC_W), .IW(IW), .ACK_TIMEOUT(T), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .pc(pc), .ir(ir),
        .reg_write(reg_write), .reg_dst(reg_dst), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .busy(busy), .halted(halted), .error(error), .retired(retired)
    );

    // Data-memory responder: acks the n-th access delays[n] cycles after req rises
    always @(negedge clk) begin
        if (ack_mode == 1) begin
            dmem_ack = 1'b1;
        end else if (ack_mode == 0 && dmem_req === 1'b1) begin
            if (mem_cyc >= delays[(acc_cnt - acc_start) % 64]) begin
                dmem_ack = 1'b1;
                acc_cnt++;
                mem_cyc = 0;
            end else begin
                dmem_ack = 1'b0;
                mem_cyc++;
            end
        end else begin
            dmem_ack = 1'b0;
            mem_cyc  = 0;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        start = 1'b0;
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic fill_halt;
        for (int i = 0; i < 256; i++) imem[i] = 8'hFF;
    endtask

    // One-cycle start; returns observing the first FETCH cycle
    task automatic pulse_start;
        acc_start = acc_cnt;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    // Start and wait for halt; cyc = cycles spent executing
    task automatic run_program(output int cyc, output bit ok);
        pulse_start;
        cyc = 1;
        ok  = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            if (halted === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick;
            cyc++;
        end
        cyc = cyc - 1;
    endtask

    // Instruction-level reference: each instruction costs its nominal latency
    // plus its ack wait; a wait of T or more cycles ends the run with error.
    function automatic void model_run(output int e_cyc, output logic [7:0] e_pc,
                                      output int e_ret, output logic e_err,
                                      output logic [7:0] e_ir);
        logic [7:0] p;
        logic [7:0] ins;
        int         acc;
        bit         done;
        p = 8'd0; acc = 0; done = 1'b0;
        e_cyc = 0; e_ret = 0; e_err = 1'b0; e_ir = 8'd0;
        for (int n = 0; n < 1000 && !done; n++) begin
            ins  = imem[p];
            e_ir = ins;
            p    = p + 8'd1;
            case (ins[7:6])
                2'b00: begin e_cyc += 4; e_ret++; end
                2'b01, 2'b10: begin
                    if (delays[acc % 64] >= T) begin
                        e_cyc += 3 + T; e_err = 1'b1; done = 1'b1;
                    end else begin
                        e_cyc += ((ins[7:6] == 2'b01) ? 5 : 4) + delays[acc % 64];
                        e_ret++; acc++;
                    end
                end
                default: begin
                    e_cyc += 3; e_ret++;
                    p = p + {{2{ins[5]}}, ins[5:0]};
                    if (ins[5:0] == 6'h3F) done = 1'b1;
                end
            endcase
        end
        e_pc = p;
    endfunction

    task automatic test_reset;
        ack_mode = 2;
        do_reset;
        repeat (10) tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", halted); end
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc got=%h exp=00", pc); end
        checks++; if (ir !== 8'h00) begin errors++; $display("FAIL reset_ir got=%h exp=00", ir); end
        checks++; if (retired !== 16'd0) begin errors++; $display("FAIL reset_retired got=%0d exp=0", retired); end
        checks++; if ({dmem_req, dmem_we, reg_write, error} !== 4'b0) begin errors++; $display("FAIL reset_ctrl got=%b exp=0000", {dmem_req, dmem_we, reg_write, error}); end
    endtask

    task automatic test_add;
        int rw_bad;
        rw_bad = 0;
        fill_halt; imem[0] = 8'h1B; ack_mode = 2;
        do_reset;
        pulse_start;
        for (int c = 1; c <= 4; c++) begin
            if (c == 2) begin
                checks++; if (ir !== 8'h1B) begin errors++; $display("FAIL add_ir got=%h exp=1b", ir); end
            end
            if (reg_write !== (c == 4)) rw_bad++;
            if (c == 4) begin
                checks++; if ({reg_dst, mem_to_reg} !== 2'b10) begin errors++; $display("FAIL add_wb_ctrl got=%b exp=10", {reg_dst, mem_to_reg}); end
            end
            tick;
        end
        checks++; if (rw_bad != 0) begin errors++; $display("FAIL add_reg_write_timing bad_cycles=%0d exp=0", rw_bad); end
        checks++; if (retired !== 16'd1) begin errors++; $display("FAIL add_retired got=%0d exp=1", retired); end
        checks++; if (pc !== 8'h01) begin errors++; $display("FAIL add_pc got=%h exp=01", pc); end
    endtask

    task automatic test_lw_delayed;
        int req_cnt, we_cnt;
        req_cnt = 0; we_cnt = 0;
        fill_halt; imem[0] = 8'h49;
        delays[0] = 3; ack_mode = 0;
        do_reset;
        pulse_start;
        for (int c = 1; c <= 8; c++) begin
            if (dmem_req === 1'b1) req_cnt++;
            if (dmem_req === 1'b1 && dmem_we !== 1'b0) we_cnt++;
            if (c == 8) begin
                checks++; if ({reg_write, mem_to_reg, alu_src, reg_dst} !== 4'b1110) begin errors++; $display("FAIL lw_wb_ctrl got=%b exp=1110", {reg_write, mem_to_reg, alu_src, reg_dst}); end
            end
            tick;
        end
        checks++; if (req_cnt != 4) begin errors++; $display("FAIL lw_req_cycles got=%0d exp=4", req_cnt); end
        checks++; if (we_cnt != 0) begin errors++; $display("FAIL lw_we_cycles got=%0d exp=0", we_cnt); end
        checks++; if (retired !== 16'd1) begin errors++; $display("FAIL lw_retired got=%0d exp=1", retired); end
    endtask

    task automatic test_sw_same_cycle;
        int req_cnt, we_cnt, rw_cnt;
        req_cnt = 0; we_cnt = 0; rw_cnt = 0;
        fill_halt; imem[0] = 8'h99; ack_mode = 1;
        do_reset;
        repeat (3) tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sw_idle_ack_ignored busy=%b exp=0", busy); end
        pulse_start;
        for (int c = 1; c <= 4; c++) begin
            if (dmem_req === 1'b1) req_cnt++;
            if (dmem_req === 1'b1 && dmem_we === 1'b1) we_cnt++;
            if (reg_write !== 1'b0) rw_cnt++;
            tick;
        end
        checks++; if (req_cnt != 1 || we_cnt != 1) begin errors++; $display("FAIL sw_req_we got=%0d/%0d exp=1/1", req_cnt, we_cnt); end
        checks++; if (rw_cnt != 0) begin errors++; $display("FAIL sw_reg_write got=%0d exp=0", rw_cnt); end
        checks++; if (pc !== 8'h01 || busy !== 1'b1) begin errors++; $display("FAIL sw_next_fetch pc=%h busy=%b exp=01/1", pc, busy); end
        checks++; if (retired !== 16'd1) begin errors++; $display("FAIL sw_retired got=%0d exp=1", retired); end
        ack_mode = 2;
    endtask

    task automatic test_jump_halt;
        fill_halt; imem[0] = 8'hC1; imem[1] = 8'h00; ack_mode = 2;
        do_reset;
        pulse_start;
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL jmp_pc0 got=%h exp=00", pc); end
        repeat (3) tick;
        checks++; if (pc !== 8'h02) begin errors++; $display("FAIL jmp_pc_target got=%h exp=02", pc); end
        repeat (3) tick;
        checks++; if ({halted, busy} !== 2'b10) begin errors++; $display("FAIL jmp_halt got=%b exp=10", {halted, busy}); end
        checks++; if (pc !== 8'h02 || retired !== 16'd2) begin errors++; $display("FAIL jmp_halt_state pc=%h retired=%0d exp=02/2", pc, retired); end
        repeat (3) tick;
        checks++; if (halted !== 1'b1 || pc !== 8'h02 || ir !== 8'hFF) begin errors++; $display("FAIL jmp_halt_hold halted=%b pc=%h ir=%h exp=1/02/ff", halted, pc, ir); end
        pulse_start;
        checks++; if (pc !== 8'h00 || busy !== 1'b1 || retired !== 16'd0) begin errors++; $display("FAIL jmp_restart pc=%h busy=%b retired=%0d exp=00/1/0", pc, busy, retired); end
    endtask

    task automatic test_pc_wrap;
        int cyc;
        bit ok;
        fill_halt; imem[0] = 8'hFE; imem[8'hFF] = 8'hC1; ack_mode = 2;
        do_reset;
        run_program(cyc, ok);
        checks++; if (!ok || cyc != 9) begin errors++; $display("FAIL wrap_cycles got=%0d ok=%0d exp=9", cyc, ok); end
        checks++; if (pc !== 8'h01 || retired !== 16'd3) begin errors++; $display("FAIL wrap_state pc=%h retired=%0d exp=01/3", pc, retired); end
    endtask

    task automatic test_watchdog_reset;
        int  req_cnt;
        bit  found;
        req_cnt = 0; found = 1'b0;
        fill_halt; imem[0] = 8'h49; ack_mode = 2;
        do_reset;
        pulse_start;
        for (int k = 0; k < 60; k++) begin
            if (halted === 1'b1) begin
                found = 1'b1;
                break;
            end
            if (dmem_req === 1'b1) req_cnt++;
            tick;
        end
        checks++; if (!found) begin errors++; $display("FAIL wd_halt_timeout halted=%b exp=1", halted); end
        checks++; if (req_cnt != T) begin errors++; $display("FAIL wd_mem_cycles got=%0d exp=%0d", req_cnt, T); end
        checks++; if (error !== 1'b1 || retired !== 16'd0) begin errors++; $display("FAIL wd_error error=%b retired=%0d exp=1/0", error, retired); end
        pulse_start;
        checks++; if (error !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL wd_restart error=%b busy=%b exp=0/1", error, busy); end
        repeat (3) tick;
        checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL wd_rerun_mem dmem_req=%b exp=1", dmem_req); end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        checks++; if ({busy, halted, dmem_req, error} !== 4'b0 || pc !== 8'h00) begin errors++; $display("FAIL wd_mid_reset flags=%b pc=%h exp=0000/00", {busy, halted, dmem_req, error}, pc); end
    endtask

    task automatic test_random;
        int         len, e_cyc, e_ret, cyc;
        logic [7:0] e_pc, e_ir;
        logic       e_err;
        bit         ok;
        for (int it = 0; it < 25; it++) begin
            fill_halt;
            len = $urandom_range(3, 12);
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 3))
                    0:       imem[i] = {2'b00, 6'($urandom)};
                    1:       imem[i] = {2'b01, 6'($urandom)};
                    2:       imem[i] = {2'b10, 6'($urandom)};
                    default: imem[i] = {2'b11, 6'($urandom_range(0, 3))};
                endcase
            end
            for (int j = 0; j < 64; j++) begin
                delays[j] = ($urandom_range(0, 9) == 0) ? $urandom_range(T, T + 5) : $urandom_range(0, 4);
            end
            ack_mode = 0;
            if (it % 3 == 0) do_reset;
            model_run(e_cyc, e_pc, e_ret, e_err, e_ir);
            run_program(cyc, ok);
            checks++; if (!ok || cyc != e_cyc) begin errors++; $display("FAIL rand%0d_cycles got=%0d ok=%0d exp=%0d", it, cyc, ok, e_cyc); end
            checks++; if (pc !== e_pc || ir !== e_ir) begin errors++; $display("FAIL rand%0d_pc_ir got=%h/%h exp=%h/%h", it, pc, ir, e_pc, e_ir); end
            checks++; if (retired !== 16'(e_ret) || error !== e_err) begin errors++; $display("FAIL rand%0d_ret_err got=%0d/%b exp=%0d/%b", it, retired, error, e_ret, e_err); end
        end
        ack_mode = 2;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        fill_halt;
        for (int j = 0; j < 64; j++) delays[j] = 0;
        test_reset;
        test_add;
        test_lw_delayed;
        test_sw_same_cycle;
        test_jump_halt;
        test_pc_wrap;
        test_watchdog_reset;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
